klingon_display_scan: RTL and testbench

Time-multiplexed refresh controller for a 4-digit seven-segment display. It shares one 4-bit Klingon digit decoder (NUM in, SEG out) across four digits. It holds a 16-bit display word, drives the decoder input NUM and the active-low digit enables AN, and inserts guard (all-off) cycles between digits to prevent ghosting. New words enter through a valid/ready handshake and take effect only at frame boundaries, so a frame never shows mixed old and new data.

---
 rtl/klingon_display_scan.sv | 107 ++++++++++
 tb/tb_klingon_display_scan.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/klingon_display_scan.sv
// Refresh controller for a 4-digit seven-segment display sharing one Klingon digit decoder.
// New words are double-buffered and applied only at frame boundaries.
module klingon_display_scan #(
   parameter int DIV   = 50000,
   parameter int GUARD = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] DATA_IN,
   input  logic        LOAD_VALID,
   output logic        LOAD_READY,
   input  logic        BLANK_LZ,
   output logic [3:0]  NUM,
   output logic [3:0]  AN,
   output logic        FRAME_TICK
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST_O  = CW'(DIV - 1);
   localparam logic [CW-1:0] GUARD_O = CW'(GUARD);

   logic [15:0]   r_active;
   logic [15:0]   r_shadow;
   logic          r_pend;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_dig;

   logic          w_last;
   logic          w_swap;
   logic          w_xfer;
   logic [CW-1:0] w_cnt_n;
   logic [1:0]    w_dig_n;
   logic [15:0]   w_act_n;
   logic          w_pend_n;
   logic [3:0]    w_num_n;
   logic [3:0]    w_an_n;
   logic          w_tick_n;

   // A digit is dark when every more-significant nibble, and its own, is zero.
   function automatic logic f_blank(input logic [15:0] w, input logic [1:0] d, input logic en);
      logic b;
      case (d)
         2'd3:    b = (w[15:12] == 4'd0);
         2'd2:    b = (w[15:8]  == 8'd0);
         2'd1:    b = (w[15:4]  == 12'd0);
         default: b = 1'b0;
      endcase
      return en && b;
   endfunction

   function automatic logic [3:0] f_nib(input logic [15:0] w, input logic [1:0] d);
      logic [3:0] n;
      case (d)
         2'd0:    n = w[3:0];
         2'd1:    n = w[7:4];
         2'd2:    n = w[11:8];
         default: n = w[15:12];
      endcase
      return n;
   endfunction

   // Outputs are computed for the upcoming cycle so they can come straight from flops.
   always_comb begin
      w_last   = (r_cnt == LAST_O);
      w_cnt_n  = w_last ? '0 : r_cnt + 1'b1;
      w_dig_n  = w_last ? r_dig + 2'd1 : r_dig;
      w_swap   = w_last && (r_dig == 2'd3) && r_pend;
      w_xfer   = LOAD_VALID && !r_pend;
      w_act_n  = w_swap ? r_shadow : r_active;
      w_pend_n = r_pend;
      if (w_swap)
         w_pend_n = 1'b0;
      else if (w_xfer)
         w_pend_n = 1'b1;
      w_num_n  = f_nib(w_act_n, w_dig_n);
      w_an_n   = 4'b1111;
      if (w_cnt_n >= GUARD_O && !f_blank(w_act_n, w_dig_n, BLANK_LZ))
         w_an_n = ~(4'b0001 << w_dig_n);
      w_tick_n = (w_cnt_n == LAST_O) && (w_dig_n == 2'd3);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_active   <= '0;
         r_shadow   <= '0;
         r_pend     <= 1'b0;
         r_cnt      <= '0;
         r_dig      <= 2'd0;
         AN         <= 4'b1111;
         NUM        <= 4'd0;
         FRAME_TICK <= 1'b0;
         LOAD_READY <= 1'b1;
      end else begin
         if (w_xfer)
            r_shadow <= DATA_IN;
         r_active   <= w_act_n;
         r_pend     <= w_pend_n;
         r_cnt      <= w_cnt_n;
         r_dig      <= w_dig_n;
         AN         <= w_an_n;
         NUM        <= w_num_n;
         FRAME_TICK <= w_tick_n;
         LOAD_READY <= !w_pend_n;
      end
   end

endmodule

// File: tb/tb_klingon_display_scan.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor compares them.
module tb_klingon_display_scan;

   logic        CLK;
   logic        RST;
   logic [15:0] DATA_IN;
   logic        LOAD_VALID;
   logic        LOAD_READY;
   logic        BLANK_LZ;
   logic [3:0]  NUM;
   logic [3:0]  AN;
   logic        FRAME_TICK;

   klingon_display_scan #(.DIV(4), .GUARD(1)) dut (
      .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .LOAD_VALID(LOAD_VALID),
      .LOAD_READY(LOAD_READY), .BLANK_LZ(BLANK_LZ), .NUM(NUM), .AN(AN),
      .FRAME_TICK(FRAME_TICK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int gcyc = 0;
   always @(posedge CLK) gcyc <= gcyc + 1;

   typedef struct {
      int         t;
      int         f;
      logic [3:0] e;
      string      nm;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // Field codes: 0 AN, 1 NUM, 2 FRAME_TICK, 3 LOAD_READY.
   task automatic push(input int t, input int f, input logic [3:0] e, input string nm);
      exp_t x;
      int   i;
      x.t = t; x.f = f; x.e = e; x.nm = nm;
      i = q.size();
      while (i > 0 && q[i-1].t > t) i--;
      q.insert(i, x);
   endtask

   function automatic logic blk(input logic [15:0] w, input int s, input logic en);
      logic b;
      case (s)
         3:       b = (w[15:12] == 4'd0);
         2:       b = (w[15:8]  == 8'd0);
         1:       b = (w[15:4]  == 12'd0);
         default: b = 1'b0;
      endcase
      return en && b;
   endfunction

   // DIV=4, GUARD=1: offset 0 of each slot dark, digit s enabled on offsets 1..3.
   task automatic push_frame(input int t0, input logic [15:0] w, input logic bl, input int n);
      for (int c = 0; c < n; c++) begin
         int s;
         int o;
         logic [3:0] an;
         s  = (c / 4) % 4;
         o  = c % 4;
         an = (o < 1 || blk(w, s, bl)) ? 4'b1111 : ~(4'b0001 << s);
         push(t0 + c, 0, an, "an");
         push(t0 + c, 1, w[s*4 +: 4], "num");
         push(t0 + c, 2, {3'b000, ((c % 16) == 15)}, "tick");
      end
   endtask

   task automatic push_rdy(input int t0, input int t1, input logic v);
      for (int t = t0; t <= t1; t++) push(t, 3, {3'b000, v}, "ready");
   endtask

   task automatic push_rst(input int t);
      push(t, 0, 4'b1111, "rst_an");
      push(t, 1, 4'd0, "rst_num");
      push(t, 2, 4'd0, "rst_tick");
      push(t, 3, 4'd1, "rst_ready");
   endtask

   task automatic wait_to(input int t);
      while (gcyc < t) begin
         @(posedge CLK);
         #1;
      end
   endtask

   always @(negedge CLK) begin
      while (q.size() > 0 && q[0].t <= gcyc) begin
         exp_t x;
         logic [3:0] act;
         x = q.pop_front();
         case (x.f)
            0:       act = AN;
            1:       act = NUM;
            2:       act = {3'b000, FRAME_TICK};
            default: act = {3'b000, LOAD_READY};
         endcase
         checks++;
         if (x.t != gcyc) begin
            errors++;
            $display("FAIL %s cycle %0d: expectation missed (now %0d)", x.nm, x.t, gcyc);
         end else if (act !== x.e) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", x.nm, x.t, act, x.e);
         end
      end
   end

   int b;
   int b2;

   initial begin
      RST = 1'b1; DATA_IN = 16'h0; LOAD_VALID = 1'b0; BLANK_LZ = 1'b0;
      push_rst(1);
      push_rst(2);
      wait_to(3);
      RST = 1'b0;
      b = gcyc;

      push_frame(b + 0,  16'h0000, 1'b0, 16);
      push_frame(b + 16, 16'h1234, 1'b0, 16);
      push_frame(b + 32, 16'hABCD, 1'b0, 16);
      push_frame(b + 48, 16'h0050, 1'b1, 16);
      push_frame(b + 64, 16'h0050, 1'b0, 16);
      push_frame(b + 80, 16'h0050, 1'b0, 16);
      push_frame(b + 96, 16'h9999, 1'b0, 7);
      push_rdy(b + 0,  b + 2,  1'b1);
      push_rdy(b + 3,  b + 15, 1'b0);
      push_rdy(b + 16, b + 16, 1'b1);
      push_rdy(b + 17, b + 31, 1'b0);
      push_rdy(b + 32, b + 34, 1'b1);
      push_rdy(b + 35, b + 47, 1'b0);
      push_rdy(b + 48, b + 79, 1'b1);
      push_rdy(b + 80, b + 95, 1'b0);
      push_rdy(b + 96, b + 98, 1'b1);
      push_rdy(b + 99, b + 102, 1'b0);
      push_rst(b + 103);

      wait_to(b + 2);  LOAD_VALID = 1'b1; DATA_IN = 16'h1234;
      wait_to(b + 3);  LOAD_VALID = 1'b0;
      // ABCD is held under backpressure until the frame boundary frees the buffer.
      wait_to(b + 5);  LOAD_VALID = 1'b1; DATA_IN = 16'hABCD;
      wait_to(b + 17); LOAD_VALID = 1'b0;
      wait_to(b + 34); LOAD_VALID = 1'b1; DATA_IN = 16'h0050;
      wait_to(b + 35); LOAD_VALID = 1'b0;
      wait_to(b + 40); BLANK_LZ = 1'b1;
      wait_to(b + 63); BLANK_LZ = 1'b0;
      // Load lands on the FRAME_TICK cycle: applied one frame later.
      wait_to(b + 79); LOAD_VALID = 1'b1; DATA_IN = 16'h9999;
      wait_to(b + 80); LOAD_VALID = 1'b0;
      wait_to(b + 98); LOAD_VALID = 1'b1; DATA_IN = 16'h7777;
      wait_to(b + 99); LOAD_VALID = 1'b0;
      wait_to(b + 102); RST = 1'b1;
      wait_to(b + 103); RST = 1'b0;
      b2 = gcyc;
      push_frame(b2, 16'h0000, 1'b0, 32);
      push_rdy(b2, b2 + 31, 1'b1);

      wait_to(b2 + 34);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d expectations never compared, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
